// File: rtl/scan_test_ctrl.sv
// rtl/scan_test_ctrl.sv - scan-chain test sequencer: load, shift, capture, unload, compare
// Every output is a flop; control outputs are registered from the next state so they line up with it.
module scan_test_ctrl #(
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic [CHAIN_LEN-1:0] pat_expect,
    input  logic                 pat_last,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 chain_clk_en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     fail_count,
    output logic [CNT_W-1:0]     pat_count
);

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_LOAD    = 6'b000010,
        S_SHIFT   = 6'b000100,
        S_CAPTURE = 6'b001000,
        S_UNLOAD  = 6'b010000,
        S_DONE    = 6'b100000
    } state_t;

    localparam int              CW   = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t                 r_state;
    state_t                 w_next;
    logic [CW-1:0]          r_cnt;
    logic [CHAIN_LEN-1:0]   r_stim_sh;
    logic [CHAIN_LEN-1:0]   r_exp_cur;
    logic [CHAIN_LEN-1:0]   r_exp_next;
    logic                   r_last;
    logic                   r_first;
    logic                   r_win_err;
    logic [CNT_W-1:0]       r_fail;
    logic [CNT_W-1:0]       r_pat;
    logic                   r_pass;
    logic                   r_scan_en;
    logic                   r_clk_en;
    logic                   r_pat_ready;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_in_win;
    logic                   w_cnt_last;
    logic                   w_cmp_on;
    logic [CW-1:0]          w_idx;
    logic                   w_exp_bit;
    logic                   w_bit_err;
    logic                   w_win_fail;
    logic [CNT_W-1:0]       w_fail_nx;

    assign w_accept   = (r_state == S_LOAD) && pat_valid;
    assign w_in_win   = (r_state == S_SHIFT) || (r_state == S_UNLOAD);
    assign w_cnt_last = (r_cnt == LAST);
    // The first shift-out of a session holds whatever the chain had before, so it is never judged.
    assign w_cmp_on   = ((r_state == S_SHIFT) && !r_first) || (r_state == S_UNLOAD);
    assign w_idx      = LAST - r_cnt;
    assign w_exp_bit  = (r_state == S_UNLOAD) ? r_exp_next[w_idx] : r_exp_cur[w_idx];
    assign w_bit_err  = w_cmp_on && (scan_out != w_exp_bit);
    assign w_win_fail = w_in_win && w_cnt_last && (r_win_err || w_bit_err);
    assign w_fail_nx  = (w_win_fail && (r_fail != CMAX)) ? r_fail + 1'b1 : r_fail;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (start) w_next = S_LOAD;
            S_LOAD:    if (pat_valid) w_next = S_SHIFT;
            S_SHIFT:   if (w_cnt_last) w_next = S_CAPTURE;
            S_CAPTURE: w_next = r_last ? S_UNLOAD : S_LOAD;
            S_UNLOAD:  if (w_cnt_last) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_stim_sh   <= '0;
            r_exp_cur   <= '0;
            r_exp_next  <= '0;
            r_last      <= 1'b0;
            r_first     <= 1'b0;
            r_win_err   <= 1'b0;
            r_fail      <= '0;
            r_pat       <= '0;
            r_pass      <= 1'b0;
            r_scan_en   <= 1'b0;
            r_clk_en    <= 1'b1;
            r_pat_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_scan_en   <= (w_next == S_SHIFT) || (w_next == S_UNLOAD);
            r_clk_en    <= (w_next != S_LOAD);
            r_pat_ready <= (w_next == S_LOAD);
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);

            if (w_in_win) begin
                r_cnt     <= w_cnt_last ? '0 : r_cnt + 1'b1;
                r_win_err <= w_cnt_last ? 1'b0 : (r_win_err || w_bit_err);
            end else begin
                r_cnt     <= '0;
                r_win_err <= 1'b0;
            end

            // scan_in is the MSB of this register; zero fill leaves scan_in low during unload.
            if (w_accept) begin
                r_stim_sh  <= pat_data;
                r_exp_cur  <= r_exp_next;
                r_exp_next <= pat_expect;
                r_last     <= pat_last;
            end else if (r_state == S_SHIFT) begin
                r_stim_sh <= r_stim_sh << 1;
            end

            r_fail <= w_fail_nx;

            if (r_state == S_CAPTURE) begin
                r_first <= 1'b0;
                if (r_pat != CMAX) r_pat <= r_pat + 1'b1;
            end

            if (w_next == S_DONE) r_pass <= (w_fail_nx == '0);

            if ((r_state == S_IDLE) && start) begin
                r_fail  <= '0;
                r_pat   <= '0;
                r_pass  <= 1'b0;
                r_first <= 1'b1;
            end
        end
    end

    assign pat_ready    = r_pat_ready;
    assign scan_en      = r_scan_en;
    assign scan_in      = r_stim_sh[CHAIN_LEN-1];
    assign chain_clk_en = r_clk_en;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign fail_count   = r_fail;
    assign pat_count    = r_pat;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb/tb_scan_test_ctrl.sv - randomized bench for scan_test_ctrl with an inverting-capture chain model
module tb_scan_test_ctrl;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         pat_valid = 1'b0;
    logic [L-1:0] pat_data = '0;
    logic [L-1:0] pat_expect = '0;
    logic         pat_last = 1'b0;

    logic         pat_ready, scan_en, scan_in, chain_clk_en, busy, done, pass;
    logic [7:0]   fail_count, pat_count;
    logic         pat_ready_s, scan_en_s, scan_in_s, chain_clk_en_s, busy_s, done_s, pass_s;
    logic [1:0]   fail_count_s, pat_count_s;

    logic [L-1:0] chain_a = '0;
    logic [L-1:0] chain_b = '0;
    wire          scan_out_a = chain_a[L-1];
    wire          scan_out_b = chain_b[L-1];

    int checks = 0;
    int failures = 0;
    int cyc;

    logic [L-1:0] pd [16];
    logic [L-1:0] pe [16];
    int           stall [16];
    logic         tr_si [512];
    logic         tr_se [512];
    logic         tr_so [512];

    scan_test_ctrl #(.CHAIN_LEN(L), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pat_data(pat_data), .pat_expect(pat_expect), .pat_last(pat_last), .scan_en(scan_en),
        .scan_in(scan_in), .scan_out(scan_out_a), .chain_clk_en(chain_clk_en), .busy(busy),
        .done(done), .pass(pass), .fail_count(fail_count), .pat_count(pat_count)
    );

    scan_test_ctrl #(.CHAIN_LEN(L), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(pat_ready_s),
        .pat_data(pat_data), .pat_expect(pat_expect), .pat_last(pat_last), .scan_en(scan_en_s),
        .scan_in(scan_in_s), .scan_out(scan_out_b), .chain_clk_en(chain_clk_en_s), .busy(busy_s),
        .done(done_s), .pass(pass_s), .fail_count(fail_count_s), .pat_count(pat_count_s)
    );

    always #5 clk = ~clk;

    // Gated scan chain: shift toward position L-1 when scan_en, otherwise capture D = ~Q.
    always @(posedge clk) begin
        if (chain_clk_en)   chain_a <= scan_en ? {chain_a[L-2:0], scan_in} : ~chain_a;
        if (chain_clk_en_s) chain_b <= scan_en_s ? {chain_b[L-2:0], scan_in_s} : ~chain_b;
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives one session from cycle 0 (start high) and checks results against the model.
    task automatic run_session(input int n, input bit inj, input string name);
        int  idx, stl, exp_f, exp_done, stall_tot, exp_fs, exp_ps;
        bit  got;
        exp_f = 0;
        stall_tot = 0;
        for (int i = 0; i < n; i++) begin
            if (pe[i] !== ~pd[i]) exp_f++;
            stall_tot += stall[i];
        end
        exp_done = (L + 2) * n + L + 1 + stall_tot;
        exp_fs = (exp_f > 3) ? 3 : exp_f;
        exp_ps = (n > 3) ? 3 : n;
        start = 1'b1;
        pat_valid = 1'b0;
        cyc = 0;
        idx = 0;
        stl = stall[0];
        got = 1'b0;
        while (cyc < 400 && !got) begin
            tick();
            start = 1'b0;
            tr_si[cyc] = scan_in;
            tr_se[cyc] = scan_en;
            tr_so[cyc] = scan_out_a;
            if (done) begin
                got = 1'b1;
                checks += 7;
                if (cyc != exp_done) begin
                    failures++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, cyc, exp_done);
                end
                if (pass !== (exp_f == 0)) begin
                    failures++; $display("FAIL %s pass got=%b exp=%b", name, pass, exp_f == 0);
                end
                if (fail_count !== 8'(exp_f)) begin
                    failures++; $display("FAIL %s fail_count got=%0d exp=%0d", name, fail_count, exp_f);
                end
                if (pat_count !== 8'(n)) begin
                    failures++; $display("FAIL %s pat_count got=%0d exp=%0d", name, pat_count, n);
                end
                if (fail_count_s !== 2'(exp_fs)) begin
                    failures++; $display("FAIL %s fail_count_sat got=%0d exp=%0d", name, fail_count_s, exp_fs);
                end
                if (pat_count_s !== 2'(exp_ps)) begin
                    failures++; $display("FAIL %s pat_count_sat got=%0d exp=%0d", name, pat_count_s, exp_ps);
                end
                if (busy !== 1'b1) begin
                    failures++; $display("FAIL %s busy_in_done got=%b exp=1", name, busy);
                end
            end else if (pat_ready && idx < n) begin
                if (stl > 0) begin
                    pat_valid = 1'b0;
                    pat_data = L'($urandom);
                    pat_expect = L'($urandom);
                    checks++;
                    if (chain_clk_en !== 1'b0) begin
                        failures++; $display("FAIL %s stall_clk_en got=%b exp=0 cycle=%0d", name, chain_clk_en, cyc);
                    end
                    stl--;
                end else begin
                    pat_valid = 1'b1;
                    pat_data = pd[idx];
                    pat_expect = pe[idx];
                    pat_last = (idx == n - 1);
                    idx++;
                    if (idx < n) stl = stall[idx];
                end
            end else begin
                pat_valid = 1'($urandom);
                pat_data = L'($urandom);
                pat_expect = L'($urandom);
                pat_last = 1'($urandom);
                if (inj && busy && !pat_ready) start = 1'($urandom_range(0, 1));
            end
        end
        pat_valid = 1'b0;
        start = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s done_timeout got=none exp=cycle %0d", name, exp_done);
        end else begin
            tick();
            checks += 3;
            if (done !== 1'b0) begin
                failures++; $display("FAIL %s done_width got=%b exp=0", name, done);
            end
            if (busy !== 1'b0) begin
                failures++; $display("FAIL %s idle_busy got=%b exp=0", name, busy);
            end
            if (fail_count !== 8'(exp_f)) begin
                failures++; $display("FAIL %s fail_hold got=%0d exp=%0d", name, fail_count, exp_f);
            end
        end
    endtask

    task automatic clear_stalls;
        for (int i = 0; i < 16; i++) stall[i] = 0;
    endtask

    task automatic check_reset_vals(input string name);
        logic [10:0] got;
        logic [10:0] want;
        got  = {scan_en, scan_in, chain_clk_en, pat_ready, busy, done, pass, fail_count[3:0]};
        want = 11'b00100000000;
        checks += 2;
        if (got !== want) begin
            failures++; $display("FAIL %s reset_outputs got=%b exp=%b", name, got, want);
        end
        if ({fail_count, pat_count} !== 16'h0) begin
            failures++; $display("FAIL %s reset_counts got=%h exp=0000", name, {fail_count, pat_count});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom);
            pat_valid = 1'($urandom);
            pat_data = L'($urandom);
            pat_expect = L'($urandom);
            pat_last = 1'($urandom);
            tick();
            check_reset_vals("reset_hold");
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pat_valid = 1'($urandom);
            tick();
            checks++;
            if ({busy, pat_ready, scan_en} !== 3'b000) begin
                failures++; $display("FAIL reset_release idle got=%b exp=000", {busy, pat_ready, scan_en});
            end
        end
        pat_valid = 1'b0;
    endtask

    task automatic test_single;
        clear_stalls();
        pd[0] = 3'b101;
        pe[0] = 3'b010;
        run_session(1, 1'b0, "single");
        checks += 3;
        if ({tr_si[2], tr_si[3], tr_si[4]} !== 3'b101) begin
            failures++; $display("FAIL single scan_in got=%b exp=101", {tr_si[2], tr_si[3], tr_si[4]});
        end
        if ({tr_se[2], tr_se[3], tr_se[4], tr_se[5]} !== 4'b1110) begin
            failures++; $display("FAIL single scan_en got=%b exp=1110", {tr_se[2], tr_se[3], tr_se[4], tr_se[5]});
        end
        if ({tr_so[6], tr_so[7], tr_so[8]} !== 3'b010) begin
            failures++; $display("FAIL single unload got=%b exp=010", {tr_so[6], tr_so[7], tr_so[8]});
        end
    endtask

    task automatic load_four;
        for (int i = 0; i < 4; i++) begin
            pd[i] = L'($urandom);
            pe[i] = ~pd[i];
        end
        pe[1] = pe[1] ^ L'($urandom_range(1, 7));
        pe[3] = pe[3] ^ L'($urandom_range(1, 7));
        pe[0] = pe[0];
    endtask

    task automatic test_multi;
        clear_stalls();
        load_four();
        run_session(4, 1'b0, "multi");
    endtask

    task automatic test_backpressure;
        clear_stalls();
        load_four();
        stall[2] = 5;
        run_session(4, 1'b0, "backpressure");
    endtask

    task automatic test_reset_mid_shift;
        clear_stalls();
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        pat_valid = 1'b1;
        pat_data = 3'b110;
        pat_expect = 3'b001;
        pat_last = 1'b1;
        tick();
        pat_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_shift");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pd[0] = L'($urandom);
        pe[0] = ~pd[0];
        run_session(1, 1'b0, "after_reset");
    endtask

    task automatic test_random;
        int n;
        for (int s = 0; s < 6; s++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                pd[i] = L'($urandom);
                pe[i] = ($urandom_range(0, 2) == 0) ? L'($urandom) : ~pd[i];
                stall[i] = $urandom_range(0, 3);
            end
            run_session(n, 1'b1, "random");
        end
    endtask

    task automatic test_saturation;
        clear_stalls();
        for (int i = 0; i < 5; i++) begin
            pd[i] = L'($urandom);
            pe[i] = pd[i];
        end
        run_session(5, 1'b1, "saturate");
    endtask

    initial begin
        cyc = 0;
        clear_stalls();
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
